// File: rtl/lamp_pkg.sv
`default_nettype none
// ============================================================================
// lamp_pkg : shared types and constants for the LED framebuffer read side
// Rev 1.0  : initial release
// ============================================================================
package lamp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LATCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int c_ch_per_board = 32;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_shifter.sv
`default_nettype none
// ============================================================================
// led_shifter : word load/shift register with serial clock divider, MSB first
// Rev 1.0     : initial release
// ============================================================================
module led_shifter
  import lamp_pkg::*;
#(
  parameter int c_bpc = 12,
  parameter int c_div = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [c_bpc-1:0] i_word,
  output logic             o_sclk,
  output logic             o_sdata,
  output logic             o_word_done
);

  localparam int c_bit_w = clog2_min1(c_bpc);
  localparam int c_div_w = clog2_min1(c_div);
  localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_bpc - 1);
  localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
  localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);

  logic [c_bpc-1:0]   sreg_q, sreg_d;
  logic [c_bit_w-1:0] bcnt_q, bcnt_d;
  logic [c_div_w-1:0] div_q, div_d;
  logic               sclk_q, sclk_d;
  logic               active_q, active_d;
  logic               phase_end;

  always_comb begin
    sreg_d      = sreg_q;
    bcnt_d      = bcnt_q;
    div_d       = div_q;
    sclk_d      = sclk_q;
    active_d    = active_q;
    phase_end   = active_q && (div_q == c_div_last);
    // Word end is the last edge of the final high phase; the FSM acts on the same edge.
    o_word_done = phase_end && sclk_q && (bcnt_q == '0);
    if (i_load) begin
      sreg_d   = i_word;
      bcnt_d   = c_bit_last;
      div_d    = '0;
      sclk_d   = 1'b0;
      active_d = 1'b1;
    end else if (phase_end) begin
      div_d = '0;
      if (!sclk_q) begin
        sclk_d = 1'b1;
      end else begin
        sclk_d = 1'b0;
        sreg_d = {sreg_q[c_bpc-2:0], 1'b0};
        if (bcnt_q == '0) begin
          active_d = 1'b0;
        end else begin
          bcnt_d = bcnt_q - c_bit_one;
        end
      end
    end else if (active_q) begin
      div_d = div_q + c_div_one;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sreg_q   <= '0;
      bcnt_q   <= '0;
      div_q    <= '0;
      sclk_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      bcnt_q   <= bcnt_d;
      div_q    <= div_d;
      sclk_q   <= sclk_d;
      active_q <= active_d;
    end
  end

  // Fully shifted register reads zero, so data idles low between words.
  assign o_sclk  = sclk_q;
  assign o_sdata = sreg_q[c_bpc-1];

endmodule
`default_nettype wire

// File: rtl/framebuffer_scanner.sv
`default_nettype none
// ============================================================================
// framebuffer_scanner : walks the framebuffer top-down, serialises every word
//                       into the LED driver chain and strobes the latch
// Rev 1.0             : initial release
// ============================================================================
module framebuffer_scanner
  import lamp_pkg::*;
#(
  parameter int c_ledboards = 30,
  parameter int c_bpc       = 12,
  parameter int c_channels  = c_ledboards * c_ch_per_board,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_div       = 2,
  parameter int c_latch     = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  output logic [c_addr_w-1:0] o_raddr,
  input  logic [c_bpc-1:0]    i_rdata,
  output logic                o_sclk,
  output logic                o_sdata,
  output logic                o_latch,
  output logic                o_busy,
  output logic                o_done
);

  localparam int c_lat_w = clog2_min1(c_latch);
  localparam logic [c_lat_w-1:0]  c_lat_last  = c_lat_w'(c_latch - 1);
  localparam logic [c_lat_w-1:0]  c_lat_one   = c_lat_w'(1);
  localparam logic [c_addr_w-1:0] c_addr_last = c_addr_w'(c_channels - 1);
  localparam logic [c_addr_w-1:0] c_addr_one  = c_addr_w'(1);

  state_t              state_q, state_d;
  logic [c_addr_w-1:0] raddr_q, raddr_d;
  logic [c_lat_w-1:0]  lcnt_q, lcnt_d;
  logic                fetch_q, fetch_d;
  logic                latch_q, latch_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                shift_load;
  logic                word_done;

  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    lcnt_d     = lcnt_q;
    fetch_d    = fetch_q;
    latch_d    = latch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    shift_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          busy_d  = 1'b1;
          raddr_d = c_addr_last;
          fetch_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Second cycle: the registered read port now presents the word.
        if (fetch_q) begin
          shift_load = 1'b1;
          fetch_d    = 1'b0;
          state_d    = ST_SHIFT;
        end else begin
          fetch_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (word_done) begin
          if (raddr_q == '0) begin
            latch_d = 1'b1;
            lcnt_d  = '0;
            state_d = ST_LATCH;
          end else begin
            raddr_d = raddr_q - c_addr_one;
            fetch_d = 1'b0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_LATCH: begin
        if (lcnt_q == c_lat_last) begin
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          lcnt_d = lcnt_q + c_lat_one;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      raddr_q <= '0;
      lcnt_q  <= '0;
      fetch_q <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      lcnt_q  <= lcnt_d;
      fetch_q <= fetch_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  led_shifter #(
    .c_bpc (c_bpc),
    .c_div (c_div)
  ) u_shifter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (shift_load),
    .i_word      (i_rdata),
    .o_sclk      (o_sclk),
    .o_sdata     (o_sdata),
    .o_word_done (word_done)
  );

  assign o_raddr = raddr_q;
  assign o_latch = latch_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanner.sv
`default_nettype none
// ============================================================================
// tb_framebuffer_scanner : directed bench, one 32-channel board, div 1 and 3
// Rev 1.0                : initial release
// ============================================================================
module tb_framebuffer_scanner;

  logic        clk;
  logic        rst;
  logic        start1, start3;
  logic [4:0]  raddr1, raddr3;
  logic [11:0] rdata1, rdata3;
  logic        sclk1, sdata1, latch1, busy1, done1;
  logic        sclk3, sdata3, latch3, busy3, done3;
  logic [11:0] mem1 [32];
  logic [11:0] mem3 [32];
  logic        sel;

  int n_assert;
  int n_fail;

  framebuffer_scanner #(
    .c_ledboards(1), .c_bpc(12), .c_div(1), .c_latch(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .o_raddr(raddr1), .i_rdata(rdata1),
    .o_sclk(sclk1), .o_sdata(sdata1), .o_latch(latch1), .o_busy(busy1), .o_done(done1)
  );

  framebuffer_scanner #(
    .c_ledboards(1), .c_bpc(12), .c_div(3), .c_latch(4)
  ) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .o_raddr(raddr3), .i_rdata(rdata3),
    .o_sclk(sclk3), .o_sdata(sdata3), .o_latch(latch3), .o_busy(busy3), .o_done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Framebuffer model: registered read, data one cycle after the address.
  always_ff @(posedge clk) begin
    rdata1 <= mem1[raddr1];
    rdata3 <= mem3[raddr3];
  end

  logic       m_sclk, m_sdata, m_latch, m_busy, m_done;
  logic [4:0] m_raddr;
  assign m_sclk  = sel ? sclk3  : sclk1;
  assign m_sdata = sel ? sdata3 : sdata1;
  assign m_latch = sel ? latch3 : latch1;
  assign m_busy  = sel ? busy3  : busy1;
  assign m_done  = sel ? done3  : done1;
  assign m_raddr = sel ? raddr3 : raddr1;

  // Observations of one frame, filled by collect().
  logic [11:0] words [32];
  int nwords, rises, busy_cnt, latch_cnt, latch_first, latch_last, last_fall;
  int done_cyc, hi_bad, lo_bad, lo_div, sd_viol, hi_zero, busy_one, wrap;
  logic [4:0] raddr_first;

  function automatic logic [11:0] pat(input int a);
    return 12'((a * 257) & 4095);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic which, input logic hold);
    if (which) start3 = 1'b1; else start1 = 1'b1;
    tick();
    if (!hold) begin
      start1 = 1'b0;
      start3 = 1'b0;
    end
  endtask

  // Called with the first post-accept sample already visible (cycle 1).
  task automatic collect(input int div, input int budget);
    logic [11:0] cur;
    int   nb, runlen;
    logic psclk, psdata, seen0;
    nwords = 0; rises = 0; busy_cnt = 0; latch_cnt = 0; latch_first = 0; latch_last = 0;
    last_fall = 0; done_cyc = 0; hi_bad = 0; lo_bad = 0; lo_div = 0; sd_viol = 0;
    hi_zero = 0; busy_one = 0; wrap = 0;
    cur = '0; nb = 0; runlen = 1; psclk = 1'b0; psdata = 1'b0; seen0 = 1'b0;
    raddr_first = m_raddr;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc > 1) tick();
      if (m_busy) busy_cnt++;
      if (m_latch) begin
        latch_cnt++;
        if (latch_first == 0) latch_first = cyc;
        latch_last = cyc;
      end
      if (cyc > 1 && m_sclk != psclk) begin
        if (m_sclk) begin
          rises++;
          if (runlen == div) lo_div++;
          else if (runlen != div + 2) lo_bad++;
          if (m_sdata !== psdata) sd_viol++;
          cur = {cur[10:0], m_sdata};
          nb++;
          if (nb == 12) begin
            if (nwords < 32) words[nwords] = cur;
            nwords++;
            nb = 0;
          end
        end else begin
          if (runlen != div) hi_bad++;
          last_fall = cyc;
        end
        runlen = 1;
      end else if (cyc > 1) begin
        runlen++;
        if (m_sclk && m_sdata !== psdata) sd_viol++;
      end
      if (m_sclk && !m_sdata) hi_zero++;
      if (m_busy && m_sdata) busy_one++;
      if (seen0 && m_raddr != 5'd0) wrap++;
      if (m_busy && m_raddr == 5'd0) seen0 = 1'b1;
      psclk  = m_sclk;
      psdata = m_sdata;
      if (m_done) begin
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_assert++;
    if ({raddr1, sclk1, sdata1, latch1, busy1, done1} !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {raddr1, sclk1, sdata1, latch1, busy1, done1});
    end
    rst = 1'b0;
    repeat (2) tick();
    n_assert++;
    if ({raddr1, busy1, latch1, done1} !== 8'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %h required 0", {raddr1, busy1, latch1, done1});
    end
  endtask

  task automatic test_frame_data();
    for (int a = 0; a < 32; a++) mem1[a] = pat(a);
    start_frame(1'b0, 1'b0);
    collect(1, 2000);
    n_assert++;
    if (raddr_first !== 5'd31) begin
      n_fail++; $display("FAIL first_addr: got %0d required 31", raddr_first);
    end
    n_assert++;
    if (rises !== 384) begin
      n_fail++; $display("FAIL sclk_rises: got %0d required 384", rises);
    end
    n_assert++;
    if (nwords !== 32) begin
      n_fail++; $display("FAIL word_count: got %0d required 32", nwords);
    end
    for (int k = 0; k < 32; k++) begin
      n_assert++;
      if (words[k] !== pat(31 - k)) begin
        n_fail++; $display("FAIL word_%0d: got %h required %h", k, words[k], pat(31 - k));
      end
    end
    n_assert++;
    if (sd_viol !== 0 || hi_bad !== 0 || lo_bad !== 0) begin
      n_fail++; $display("FAIL div1_timing: sd_viol %0d hi_bad %0d lo_bad %0d required 0", sd_viol, hi_bad, lo_bad);
    end
  endtask

  task automatic test_latch_done();
    n_assert++;
    if (done_cyc !== 837) begin
      n_fail++; $display("FAIL done_cycle: got %0d required 837", done_cyc);
    end
    n_assert++;
    if (busy_cnt !== 836) begin
      n_fail++; $display("FAIL busy_cycles: got %0d required 836", busy_cnt);
    end
    n_assert++;
    if (latch_cnt !== 4 || latch_first !== last_fall || latch_last !== 836) begin
      n_fail++;
      $display("FAIL latch_window: got len %0d first %0d last %0d fall %0d required len 4 first=fall last 836",
               latch_cnt, latch_first, latch_last, last_fall);
    end
    tick();
    n_assert++;
    if ({done1, busy1, latch1} !== 3'b000) begin
      n_fail++; $display("FAIL after_done: got %b required 000", {done1, busy1, latch1});
    end
  endtask

  task automatic test_back_to_back();
    tick();
    start_frame(1'b0, 1'b1);
    collect(1, 2000);
    n_assert++;
    if (done_cyc !== 837 || busy_cnt !== 836 || wrap !== 0) begin
      n_fail++; $display("FAIL held_start_frame: got done %0d busy %0d wrap %0d required 837 836 0", done_cyc, busy_cnt, wrap);
    end
    tick();
    n_assert++;
    if (busy1 !== 1'b0) begin
      n_fail++; $display("FAIL idle_gap: got busy %b required 0", busy1);
    end
    tick();
    n_assert++;
    if (busy1 !== 1'b1 || raddr1 !== 5'd31) begin
      n_fail++; $display("FAIL restart: got busy %b addr %0d required 1 31", busy1, raddr1);
    end
    start1 = 1'b0;
    collect(1, 2000);
    n_assert++;
    if (done_cyc !== 837 || nwords !== 32 || words[0] !== pat(31)) begin
      n_fail++; $display("FAIL second_frame: got done %0d words %0d w0 %h required 837 32 %h", done_cyc, nwords, words[0], pat(31));
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    tick();
    start_frame(1'b0, 1'b0);
    for (int cyc = 2; cyc <= 274; cyc++) tick();
    n_assert++;
    if (sclk1 !== 1'b1 || busy1 !== 1'b1 || raddr1 !== 5'd21) begin
      n_fail++; $display("FAIL pre_reset_state: got sclk %b busy %b addr %0d required 1 1 21", sclk1, busy1, raddr1);
    end
    rst = 1'b1;
    #1;
    n_assert++;
    if ({raddr1, sclk1, sdata1, latch1, busy1, done1} !== 10'd0) begin
      n_fail++; $display("FAIL async_reset: got %h required 0", {raddr1, sclk1, sdata1, latch1, busy1, done1});
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (latch1 !== 1'b0 || done1 !== 1'b0) bad++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (latch1 !== 1'b0 || busy1 !== 1'b0) bad++;
    end
    n_assert++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL no_latch_after_reset: got %0d bad cycles required 0", bad);
    end
    start_frame(1'b0, 1'b0);
    collect(1, 2000);
    bad = 0;
    for (int k = 0; k < 32; k++) if (words[k] !== pat(31 - k)) bad++;
    n_assert++;
    if (raddr_first !== 5'd31 || done_cyc !== 837 || nwords !== 32 || bad !== 0) begin
      n_fail++;
      $display("FAIL frame_after_reset: got addr %0d done %0d words %0d bad %0d required 31 837 32 0",
               raddr_first, done_cyc, nwords, bad);
    end
  endtask

  task automatic test_div3();
    int bad;
    for (int a = 0; a < 32; a++) mem3[a] = pat(a);
    sel = 1'b1;
    tick();
    start_frame(1'b1, 1'b0);
    collect(3, 4000);
    sel = 1'b0;
    n_assert++;
    if (done_cyc !== 2373 || busy_cnt !== 2372) begin
      n_fail++; $display("FAIL div3_length: got done %0d busy %0d required 2373 2372", done_cyc, busy_cnt);
    end
    n_assert++;
    if (hi_bad !== 0 || lo_bad !== 0 || lo_div !== 352) begin
      n_fail++; $display("FAIL div3_halfperiod: got hi_bad %0d lo_bad %0d lo_div %0d required 0 0 352", hi_bad, lo_bad, lo_div);
    end
    n_assert++;
    if (sd_viol !== 0 || rises !== 384) begin
      n_fail++; $display("FAIL div3_sdata: got viol %0d rises %0d required 0 384", sd_viol, rises);
    end
    bad = 0;
    for (int k = 0; k < 32; k++) if (words[k] !== pat(31 - k)) bad++;
    n_assert++;
    if (nwords !== 32 || bad !== 0) begin
      n_fail++; $display("FAIL div3_words: got %0d words %0d bad required 32 0", nwords, bad);
    end
  endtask

  task automatic test_constant_data();
    for (int a = 0; a < 32; a++) mem1[a] = 12'hFFF;
    tick();
    start_frame(1'b0, 1'b0);
    collect(1, 2000);
    n_assert++;
    if (hi_zero !== 0 || rises !== 384 || words[17] !== 12'hFFF) begin
      n_fail++; $display("FAIL all_ones: got hi_zero %0d rises %0d w17 %h required 0 384 fff", hi_zero, rises, words[17]);
    end
    n_assert++;
    if (wrap !== 0 || raddr1 !== 5'd0) begin
      n_fail++; $display("FAIL addr_no_wrap: got wrap %0d addr %0d required 0 0", wrap, raddr1);
    end
    for (int a = 0; a < 32; a++) mem1[a] = 12'h000;
    tick();
    start_frame(1'b0, 1'b0);
    collect(1, 2000);
    n_assert++;
    if (busy_one !== 0 || rises !== 384 || done_cyc !== 837) begin
      n_fail++; $display("FAIL all_zeros: got busy_one %0d rises %0d done %0d required 0 384 837", busy_one, rises, done_cyc);
    end
    tick();
    n_assert++;
    if (raddr1 !== 5'd0 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL addr_rest: got addr %0d busy %b required 0 0", raddr1, busy1);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    sel      = 1'b0;
    start1   = 1'b0;
    start3   = 1'b0;
    for (int a = 0; a < 32; a++) begin
      mem1[a] = 12'h000;
      mem3[a] = 12'h000;
    end
    test_reset();
    test_frame_data();
    test_latch_done();
    test_back_to_back();
    test_reset_midframe();
    test_div3();
    test_constant_data();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
